branch_resolve_unit: RTL

Parametrised successor to the branch comparator. Resolves all six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) in EX and registers the result for one cycle. Checks the outcome against the fetch-time prediction and trains an internal 2-bit saturating branch history table (BHT). Also serves the IF-stage prediction lookup and keeps a saturating mispredict counter. Sits between the EX stage and the fetch/hazard logic of the pipelined core.

---
 rtl/branch_resolve_unit_pkg.sv | 11 +
 rtl/branch_resolve_unit_bht_2bit.sv | 33 +++
 rtl/branch_resolve_unit.sv | 73 +++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: branch funct3 codes and 2-bit BHT counter states
package branch_resolve_unit_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bht_state_t;
  localparam bht_state_t BHT_RESET = WNT;
endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// bht_2bit: table of 2-bit saturating counters with a lookup port and an update port
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PC_LSB    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_lookup_taken,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);
  localparam int IW = $clog2(BHT_DEPTH);
  bht_state_t ctr [BHT_DEPTH];
  logic [IW-1:0] lidx, uidx;
  bht_state_t cur, nxt;
  assign lidx = IW'(i_lookup_pc >> PC_LSB);
  assign uidx = IW'(i_upd_pc >> PC_LSB);
  // lookup reads the registered table, so a same-cycle update is not yet visible
  assign o_lookup_taken = (ctr[lidx] == WT) || (ctr[lidx] == ST);
  assign cur = ctr[uidx];
  // saturating step toward the resolved direction
  always_comb nxt = i_upd_taken ? ((cur == ST) ? ST : bht_state_t'(cur + 2'd1))
                                : ((cur == SNT) ? SNT : bht_state_t'(cur - 2'd1));
  // counter array: all entries weakly not-taken after reset
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < BHT_DEPTH; i++) ctr[i] <= BHT_RESET;
    else if (i_upd_en) ctr[uidx] <= nxt;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves RV32I branches in EX, registers result, trains BHT, counts mispredicts
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PC_LSB    = 2,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_target,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_lookup_pc,
  output logic             o_lookup_taken,
  output logic             o_valid,
  output logic             o_taken,
  output logic             o_br_equal,
  output logic             o_br_less,
  output logic             o_mispredict,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_mispredict_cnt
);
  logic eq, lt, illegal, taken, en, upd, pred_q;
  assign eq      = i_rs1_data == i_rs2_data;
  assign lt      = i_funct3[1] ? (i_rs1_data < i_rs2_data) : ($signed(i_rs1_data) < $signed(i_rs2_data));
  assign illegal = i_is_branch & (i_funct3[2:1] == 2'b01);
  assign taken   = i_funct3[2] ? (lt ^ i_funct3[0]) : (~i_funct3[1] & (eq ^ i_funct3[0]));
  assign en      = ~i_stall | i_flush;
  assign upd     = i_valid & i_is_branch & ~i_stall & ~i_flush & ~illegal;
  assign o_mispredict = o_valid & ~o_illegal & (o_taken != pred_q);
  bht_2bit #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .PC_LSB(PC_LSB)) u_bht (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_lookup_pc    (i_lookup_pc),
    .o_lookup_taken (o_lookup_taken),
    .i_upd_en       (upd),
    .i_upd_pc       (i_pc),
    .i_upd_taken    (taken)
  );
  // EX result register; flush overrides stall so a killed instruction never resolves
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid       <= 1'b0;
      o_taken       <= 1'b0;
      o_br_equal    <= 1'b0;
      o_br_less     <= 1'b0;
      o_illegal     <= 1'b0;
      pred_q        <= 1'b0;
      o_redirect_pc <= '0;
    end else if (en) begin
      o_valid       <= i_valid & i_is_branch & ~i_flush;
      o_taken       <= taken;
      o_br_equal    <= eq;
      o_br_less     <= lt;
      o_illegal     <= illegal;
      pred_q        <= i_pred_taken;
      o_redirect_pc <= taken ? i_target : i_pc + XLEN'(4);
    end
  // saturating mispredict counter
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_mispredict_cnt <= '0;
    else if (o_mispredict && !(&o_mispredict_cnt)) o_mispredict_cnt <= o_mispredict_cnt + CNT_W'(1);
endmodule
